// File: rtl/csa_pipe_adder.sv
// csa_pipe_adder: 2-stage pipelined carry-select adder/subtractor.
//   Stage 1 precomputes every BLOCK-bit group's sum/carry for both possible
//   carry-ins. Stage 2 walks the carry-select chain from the real carry-in.
//   Both stages use an elastic valid/ready handshake, so the pipe runs at one
//   beat per cycle when the consumer is always ready.
// Optional build macro: CSA_PIPE_SAT_EN. When defined, a signed overflow
//   makes the result saturate to the signed limit selected by a's sign.
//   When undefined, the result wraps modulo 2^WIDTH.
module csa_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = WIDTH / BLOCK;

  // Reject parameter sets that cannot be split into whole groups.
  generate
    if (WIDTH % BLOCK != 0) begin : g_bad_split
      $fatal(1, "csa_pipe_adder: WIDTH (%0d) is not a multiple of BLOCK (%0d)",
             WIDTH, BLOCK);
    end
    if (WIDTH < 2 * BLOCK) begin : g_too_narrow
      $fatal(1, "csa_pipe_adder: WIDTH (%0d) must be at least 2*BLOCK (%0d)",
             WIDTH, 2 * BLOCK);
    end
  endgenerate

  // Operand conditioning: subtraction is A + ~B + 1.
  logic [WIDTH-1:0] b_eff;
  logic             c_first;

  assign b_eff   = sub ? ~b : b;
  assign c_first = sub ? 1'b1 : cin;

  // Per-group precompute for both carry-in values.
  logic [NBLK-1:0][BLOCK-1:0] pre_sum0, pre_sum1;
  logic [NBLK-1:0]            pre_cy0, pre_cy1;

  // Stage-1 registers.
  logic                       s1_valid;
  logic [NBLK-1:0][BLOCK-1:0] s1_sum0, s1_sum1;
  logic [NBLK-1:0]            s1_cy0, s1_cy1;
  logic                       s1_cin;
  logic                       s1_a_msb;
  logic                       s1_b_msb;

  // Stage-2 combinational selection.
  logic [NBLK-1:0][BLOCK-1:0] sel_grp;
  logic [WIDTH-1:0]           sel_sum;
  logic                       sel_cout;
  logic                       sel_ovf;
  logic [WIDTH-1:0]           res_sum;
  logic                       chain;

  // Handshake.
  logic s1_load;
  logic s2_load;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_valid && in_ready;

  // Conditional sums of every group, once assuming carry-in 0 and once 1.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    pre_sum0 = '0;
    pre_sum1 = '0;
    pre_cy0  = '0;
    pre_cy1  = '0;
    for (int k = 0; k < NBLK; k++) begin
      {pre_cy0[k], pre_sum0[k]} = {1'b0, a[k*BLOCK +: BLOCK]}
                                + {1'b0, b_eff[k*BLOCK +: BLOCK]};
      {pre_cy1[k], pre_sum1[k]} = {1'b0, a[k*BLOCK +: BLOCK]}
                                + {1'b0, b_eff[k*BLOCK +: BLOCK]}
                                + {{BLOCK{1'b0}}, 1'b1};
    end
  end

  // Stage-1 register: capture the precomputed groups on an accepted beat.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum0  <= '0;
      s1_sum1  <= '0;
      s1_cy0   <= '0;
      s1_cy1   <= '0;
      s1_cin   <= 1'b0;
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
    end else begin
      s1_valid <= s1_load || (s1_valid && !s2_load);
      if (s1_load) begin
        s1_sum0  <= pre_sum0;
        s1_sum1  <= pre_sum1;
        s1_cy0   <= pre_cy0;
        s1_cy1   <= pre_cy1;
        s1_cin   <= c_first;
        s1_a_msb <= a[WIDTH-1];
        s1_b_msb <= b_eff[WIDTH-1];
      end
    end
  end

  // Carry-select chain: each group's real carry-in picks the next group.
  always_comb begin
    sel_grp = '0;
    chain   = s1_cin;
    for (int k = 0; k < NBLK; k++) begin
      sel_grp[k] = chain ? s1_sum1[k] : s1_sum0[k];
      chain      = chain ? s1_cy1[k]  : s1_cy0[k];
    end
    sel_cout = chain;
  end

  assign sel_sum = sel_grp;
  assign sel_ovf = (s1_a_msb == s1_b_msb) && (sel_sum[WIDTH-1] != s1_a_msb);

`ifdef CSA_PIPE_SAT_EN
  // Clamp to the signed limit on overflow; the limit follows a's sign.
  always_comb begin
    res_sum = sel_sum;
    if (sel_ovf) begin
      res_sum = s1_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign res_sum = sel_sum;
`endif

  // Stage-2 register: load a resolved result, hold it while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= s2_load || (out_valid && !out_ready);
      if (s2_load) begin
        sum  <= res_sum;
        cout <= sel_cout;
        ovf  <= sel_ovf;
      end
    end
  end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Testbench for csa_pipe_adder (WIDTH=16, BLOCK=4): directed vector table,
// stall / throughput / random streams against an arithmetic reference model,
// and a mid-flight reset sequence.
module tb_csa_pipe_adder;

  localparam int WIDTH = 16;
  localparam int BLOCK = 4;
`ifdef CSA_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  always #5 clk = ~clk;

  csa_pipe_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } beat_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the operands.
  function automatic beat_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                  input logic ci, input logic sb);
    beat_t r;
    int    sa;
    int    sbv;
    int    sres;
    int    ures;
    r.a   = av;
    r.b   = bv;
    r.cin = ci;
    r.sub = sb;
    sa    = int'($signed(av));
    sbv   = int'($signed(bv));
    if (sb) begin
      sres   = sa - sbv;
      r.cout = (av >= bv);
    end else begin
      sres   = sa + sbv + int'(ci);
      ures   = int'(av) + int'(bv) + int'(ci);
      r.cout = (ures > 65535);
    end
    r.sum = sres[WIDTH-1:0];
    r.ovf = (sres > 32767) || (sres < -32768);
    if (SAT && r.ovf) r.sum = av[WIDTH-1] ? 16'h8000 : 16'h7FFF;
    return r;
  endfunction

  function automatic beat_t mk(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                               input logic sb, input logic [15:0] s, input logic co,
                               input logic ov);
    beat_t r;
    r.a = av; r.b = bv; r.cin = ci; r.sub = sb; r.sum = s; r.cout = co; r.ovf = ov;
    return r;
  endfunction

  // One isolated beat with full latency and pulse-width checks.
  task automatic send_one(input beat_t v, input string tag);
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    check({tag, " out_valid early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " sum"}, 32'(sum), 32'(v.sum));
    check({tag, " cout"}, 32'(cout), 32'(v.cout));
    check({tag, " ovf"}, 32'(ovf), 32'(v.ovf));
    @(negedge clk);
    check({tag, " out_valid pulse"}, 32'(out_valid), 32'd0);
  endtask

  // Streaming run against a queue scoreboard.
  // ready_mode: 0 always ready, 1 stall in cycles 3..6, 2 random.
  task automatic run_stream(input int n, input int ready_mode, input bit gaps,
                            input string tag, output int cycles, output bit saw_block);
    beat_t            exp_q[$];
    beat_t            cur;
    beat_t            e;
    bit               holding = 1'b0;
    bit               stalled_prev = 1'b0;
    int               sent = 0;
    int               got = 0;
    int               cyc = 0;
    logic [WIDTH-1:0] prev_sum = '0;
    logic             prev_cout = 1'b0;
    logic             prev_ovf = 1'b0;
    saw_block = 1'b0;
    while (got < n && cyc < 4000) begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(cyc >= 3 && cyc <= 6);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (!holding && sent < n && (!gaps || $urandom_range(0, 3) != 0)) begin
        cur = model(16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));
        a = cur.a; b = cur.b; cin = cur.cin; sub = cur.sub;
        in_valid = 1'b1;
        holding  = 1'b1;
      end else if (!holding) begin
        in_valid = 1'b0;
      end
      #1;
      // Two-entry pipe: input blocks only when the consumer stalls and both
      // slots hold accepted beats.
      check($sformatf("%s in_ready c%0d", tag, cyc), 32'(in_ready),
            32'(out_ready || exp_q.size() < 2));
      if (!in_ready) saw_block = 1'b1;
      if (stalled_prev) begin
        check($sformatf("%s hold valid c%0d", tag, cyc), 32'(out_valid), 32'd1);
        check($sformatf("%s hold sum c%0d", tag, cyc), 32'(sum), 32'(prev_sum));
        check($sformatf("%s hold flags c%0d", tag, cyc), 32'({cout, ovf}),
              32'({prev_cout, prev_ovf}));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check($sformatf("%s unexpected output c%0d", tag, cyc), 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("%s sum #%0d", tag, got), 32'(sum), 32'(e.sum));
          check($sformatf("%s cout #%0d", tag, got), 32'(cout), 32'(e.cout));
          check($sformatf("%s ovf #%0d", tag, got), 32'(ovf), 32'(e.ovf));
          got++;
        end
      end
      stalled_prev = out_valid && !out_ready;
      prev_sum = sum; prev_cout = cout; prev_ovf = ovf;
      if (in_valid && in_ready) begin
        exp_q.push_back(cur);
        holding = 1'b0;
        sent++;
      end
      cyc++;
    end
    check({tag, " results received"}, 32'(got), 32'(n));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("%s drained %0d", tag, i), 32'(out_valid), 32'd0);
    end
    cycles = cyc;
  endtask

  beat_t dir_tab[8];
  int    cyc_n;
  bit    blk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    dir_tab[0] = mk(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    dir_tab[1] = mk(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    dir_tab[2] = mk(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    dir_tab[3] = mk(16'h8000, 16'h0001, 1'b0, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1);
    dir_tab[4] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);
    dir_tab[5] = mk(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    dir_tab[6] = mk(16'h8000, 16'h8000, 1'b0, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1);
    dir_tab[7] = mk(16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset cout/ovf", 32'({cout, ovf}), 32'd0);
    rst_n = 1'b1;
    #1 check("reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) send_one(dir_tab[i], $sformatf("dir%0d", i));

    run_stream(8, 1, 1'b0, "stall", cyc_n, blk);
    check("stall in_ready dropped", 32'(blk), 32'd1);

    run_stream(20, 0, 1'b0, "thru", cyc_n, blk);
    check("thru cycle count", 32'(cyc_n <= 22), 32'd1);

    run_stream(300, 2, 1'b1, "rand", cyc_n, blk);

    // Reset with two beats in flight: nothing of them may surface afterwards.
    @(negedge clk);
    out_ready = 1'b0;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h3333; b = 16'h4444;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset sum", 32'(sum), 32'd0);
    check("mid reset in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("no stale output %0d", i), 32'(out_valid), 32'd0);
    end
    send_one(model(16'hABCD, 16'h0123, 1'b1, 1'b0), "post-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
